uart_rx_ssd_display: RTL and testbench

- Downstream consumer of the UART receiver on the Basys-3 (100 MHz) loopback design.
- Captures each received byte (RxDV strobe plus RxByte), keeps a two-byte history, and mirrors the latest byte on LEDOut.
- Drives the 4-digit multiplexed seven-segment display as hex: latest byte on the right pair of digits, previous byte on the left pair.
- Lights an activity decimal point after each reception and blanks the anodes between digit slots to prevent ghosting.

---
 rtl/uart_rx_ssd_display_pkg.sv | 20 ++
 rtl/uart_rx_ssd_display_hex_to_ssd.sv | 14 +
 rtl/uart_rx_ssd_display.sv | 94 +++++++++
 tb/tb_uart_rx_ssd_display.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/uart_rx_ssd_display_pkg.sv
// rtl/uart_rx_ssd_display_pkg.sv - shared seven-segment constants and digit type for the UART RX display
package uart_rx_ssd_display_pkg;

  // Active-low {dp,g,f,e,d,c,b,a} codes for hex 0-F, dp off
  localparam logic [7:0] SSD_HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  localparam logic [7:0] SSD_BLANK      = 8'hFF;
  localparam logic [3:0] SSD_ANODES_OFF = 4'hF;

  typedef enum logic [1:0] {
    DIGIT0 = 2'd0,
    DIGIT1 = 2'd1,
    DIGIT2 = 2'd2,
    DIGIT3 = 2'd3
  } digit_e;

endpackage

// File: rtl/uart_rx_ssd_display_hex_to_ssd.sv
// rtl/uart_rx_ssd_display_hex_to_ssd.sv - hex nibble to active-low seven-segment pattern
module hex_to_ssd
  import uart_rx_ssd_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  logic [7:0] code;

  assign code = SSD_HEX[nibble];
  assign seg  = code[6:0];

endmodule

// File: rtl/uart_rx_ssd_display.sv
// rtl/uart_rx_ssd_display.sv - captures received UART bytes and shows the last two as hex on a 4-digit display
module uart_rx_ssd_display
  import uart_rx_ssd_display_pkg::*;
#(
  parameter int ClocksPerDigit = 100000,
  parameter int BlankClocks    = 1000,
  parameter int ActivityClocks = 25000000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       En,
  input  logic       RxDV,
  input  logic [7:0] RxByte,
  output logic [7:0] LEDOut,
  output logic [3:0] SSD_Select,
  output logic [7:0] SSD_Out
);

  localparam int RefW = $clog2(ClocksPerDigit);
  localparam int ActW = $clog2(ActivityClocks + 1);

  logic [7:0]      byte0;
  logic [7:0]      byte1;
  logic [1:0]      byte_cnt;
  logic [RefW-1:0] ref_cnt;
  digit_e          digit_idx;
  logic [ActW-1:0] act_cnt;

  logic [7:0] cur_byte;
  logic [3:0] nibble;
  logic [6:0] hex_seg;
  logic       blank;
  logic       dp_on;
  logic       show;
  logic [7:0] pattern;

  hex_to_ssd u_hex_to_ssd (
    .nibble (nibble),
    .seg    (hex_seg)
  );

  // Left digit pair shows the previous byte; each pair stays dark until it has data
  always_comb begin
    cur_byte = digit_idx[1] ? byte1 : byte0;
    nibble   = digit_idx[0] ? cur_byte[7:4] : cur_byte[3:0];
    blank    = digit_idx[1] ? (byte_cnt < 2'd2) : (byte_cnt == 2'd0);
    dp_on    = (digit_idx == DIGIT0) && (act_cnt != '0);
    pattern  = {~dp_on, blank ? SSD_BLANK[6:0] : hex_seg};
    show     = En && (ref_cnt >= RefW'(BlankClocks));
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      byte0      <= '0;
      byte1      <= '0;
      byte_cnt   <= '0;
      ref_cnt    <= '0;
      digit_idx  <= DIGIT0;
      act_cnt    <= '0;
      LEDOut     <= '0;
      SSD_Select <= SSD_ANODES_OFF;
      SSD_Out    <= SSD_BLANK;
    end else begin
      if (RxDV) begin
        byte1   <= byte0;
        byte0   <= RxByte;
        LEDOut  <= RxByte;
        act_cnt <= ActW'(ActivityClocks);
        if (byte_cnt != 2'd2) begin
          byte_cnt <= byte_cnt + 2'd1;
        end
      end else if (act_cnt != '0) begin
        act_cnt <= act_cnt - 1'b1;
      end

      // Refresh scan free-runs so toggling En never shifts the digit phase
      if (ref_cnt == RefW'(ClocksPerDigit - 1)) begin
        ref_cnt   <= '0;
        digit_idx <= digit_e'(digit_idx + 2'd1);
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end

      if (show) begin
        SSD_Select <= ~(4'b0001 << digit_idx);
        SSD_Out    <= pattern;
      end else begin
        SSD_Select <= SSD_ANODES_OFF;
        SSD_Out    <= SSD_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ssd_display.sv
// tb/tb_uart_rx_ssd_display.sv - randomized self-checking bench for uart_rx_ssd_display
module tb_uart_rx_ssd_display;

  localparam int CPD = 8;
  localparam int BLK = 2;
  localparam int ACT = 20;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       En = 1'b0;
  logic       RxDV = 1'b0;
  logic [7:0] RxByte = 8'h00;
  logic [7:0] LEDOut;
  logic [3:0] SSD_Select;
  logic [7:0] SSD_Out;

  int checks = 0;
  int errors = 0;

  logic [7:0] seg_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Reference state: edges since reset, received-byte history, last capture edge
  int         t = 0;
  logic [7:0] hist [$];
  logic [7:0] led_m = 8'h00;
  int         last_rx = 0;
  bit         have_rx = 1'b0;
  bit         en_state = 1'b1;

  uart_rx_ssd_display #(
    .ClocksPerDigit (CPD),
    .BlankClocks    (BLK),
    .ActivityClocks (ACT)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .En         (En),
    .RxDV       (RxDV),
    .RxByte     (RxByte),
    .LEDOut     (LEDOut),
    .SSD_Select (SSD_Select),
    .SSD_Out    (SSD_Out)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit en, input bit dv, input logic [7:0] data);
    logic [3:0] e_sel;
    logic [7:0] e_out;
    logic [7:0] e_led;
    logic [7:0] byt;
    logic [3:0] nib;
    int         pos;
    int         dig;
    int         n;
    bit         act;
    @(negedge Clk);
    Rst    = rst;
    En     = en;
    RxDV   = dv;
    RxByte = data;
    n   = hist.size();
    pos = t % CPD;
    dig = (t / CPD) % 4;
    act = have_rx && (t - last_rx >= 1) && (t - last_rx <= ACT);
    e_sel = 4'hF;
    e_out = 8'hFF;
    if (rst) begin
      e_led = 8'h00;
    end else begin
      e_led = dv ? data : led_m;
      if (en && pos >= BLK) begin
        e_sel = 4'hF & ~(4'b0001 << dig);
        if (dig < 2) byt = (n >= 1) ? hist[n-1] : 8'h00;
        else         byt = (n >= 2) ? hist[n-2] : 8'h00;
        nib = (dig % 2 == 1) ? byt[7:4] : byt[3:0];
        if ((dig < 2 && n == 0) || (dig >= 2 && n < 2)) e_out = 8'hFF;
        else e_out = seg_tab[nib];
        if (dig == 0 && act) e_out[7] = 1'b0;
      end
    end
    @(posedge Clk);
    #1;
    chk("led", {24'd0, LEDOut}, {24'd0, e_led});
    chk("anode", {28'd0, SSD_Select}, {28'd0, e_sel});
    chk("seg", {24'd0, SSD_Out}, {24'd0, e_out});
    if (rst) begin
      t = 0;
      hist.delete();
      have_rx = 1'b0;
      led_m = 8'h00;
    end else begin
      if (dv) begin
        hist.push_back(data);
        if (hist.size() > 2) void'(hist.pop_front());
        led_m   = data;
        last_rx = t;
        have_rx = 1'b1;
      end
      t++;
    end
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) step(1'b0, en, 1'b0, 8'h00);
  endtask

  initial begin
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("reset_led", {24'd0, LEDOut}, 32'h00);
    idle(40, 1'b1);

    step(1'b0, 1'b1, 1'b1, 8'h61);
    chk("led_61", {24'd0, LEDOut}, 32'h61);
    idle(60, 1'b1);

    step(1'b0, 1'b1, 1'b1, 8'hA5);
    chk("led_a5", {24'd0, LEDOut}, 32'hA5);
    idle(40, 1'b1);

    step(1'b0, 1'b1, 1'b1, 8'h3C);
    step(1'b0, 1'b1, 1'b1, 8'h7E);
    idle(40, 1'b1);

    idle(3, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("disabled_anode", {28'd0, SSD_Select}, 32'hF);
    step(1'b0, 1'b0, 1'b1, 8'h55);
    chk("led_55", {24'd0, LEDOut}, 32'h55);
    idle(10, 1'b0);
    idle(40, 1'b1);

    idle(4, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'h99);
    chk("rst_anode", {28'd0, SSD_Select}, 32'hF);
    chk("rst_seg", {24'd0, SSD_Out}, 32'hFF);
    idle(40, 1'b1);

    en_state = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 49) == 0) en_state = ~en_state;
      step($urandom_range(0, 299) == 0, en_state,
           $urandom_range(0, 7) == 0, 8'($urandom_range(0, 255)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
